// File: rtl/hsv_mask_bbox.sv
// HSV threshold mask with per-frame bounding box / pixel count, and a video
// overlay that draws the previous frame's box in red over the white mask.
module hsv_mask_bbox #(
    parameter logic [7:0] H_MIN = 8'd0,
    parameter logic [7:0] H_MAX = 8'd20,
    parameter logic [7:0] S_MIN = 8'd80,
    parameter logic [7:0] S_MAX = 8'd255,
    parameter logic [7:0] V_MIN = 8'd60,
    parameter logic [7:0] V_MAX = 8'd255,
    parameter int         CW    = 11
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ce,
    input  logic [7:0]    H,
    input  logic [7:0]    S,
    input  logic [7:0]    V,
    input  logic          in_de,
    input  logic          in_hsync,
    input  logic          in_vsync,
    output logic [7:0]    R,
    output logic [7:0]    G,
    output logic [7:0]    B,
    output logic          out_de,
    output logic          out_hsync,
    output logic          out_vsync,
    output logic [CW-1:0] x_min,
    output logic [CW-1:0] x_max,
    output logic [CW-1:0] y_min,
    output logic [CW-1:0] y_max,
    output logic [21:0]   pix_count,
    output logic          bbox_valid,
    output logic          frame_done
);

    typedef enum logic {UNSYNC, RUN} state_t;

    typedef struct packed {
        logic          mk;
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic          de;
        logic          hs;
        logic          vs;
    } s1_t;

    // a >= b via the borrow of a 9-bit subtract, so full-range bounds do not
    // turn into constant comparisons
    function automatic logic ge8(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] d;
        d = {1'b0, a} - {1'b0, b};
        return ~d[8];
    endfunction

    logic hin;
    logic mk;

    always_comb begin
        if (ge8(H_MAX, H_MIN)) hin = ge8(H, H_MIN) & ge8(H_MAX, H);
        else                   hin = ge8(H, H_MIN) | ge8(H_MAX, H);
    end

    assign mk = in_de & hin & ge8(S, S_MIN) & ge8(S_MAX, S) & ge8(V, V_MIN) & ge8(V_MAX, V);

    s1_t           s1;
    logic          vs2;
    logic [CW-1:0] x_cnt;
    logic [CW-1:0] y_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1    <= '0;
            vs2   <= 1'b0;
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (ce) begin
            s1    <= '{mk: mk, x: x_cnt, y: y_cnt, de: in_de, hs: in_hsync, vs: in_vsync};
            vs2   <= s1.vs;
            x_cnt <= in_de ? x_cnt + 1'b1 : '0;
            // vsync rise wins over the end-of-line increment
            if (in_vsync & ~s1.vs)     y_cnt <= '0;
            else if (s1.de & ~in_de)   y_cnt <= y_cnt + 1'b1;
        end
    end

    logic fe;
    assign fe = s1.vs & ~vs2;

    logic [CW-1:0] acc_xmin, acc_xmax, acc_ymin, acc_ymax;
    logic [21:0]   acc_cnt;
    logic [CW-1:0] nx_xmin, nx_xmax, nx_ymin, nx_ymax;
    logic [21:0]   nx_cnt;

    // On fe the accumulators restart from empty; a mask pixel on that same
    // cycle becomes the first pixel of the new frame.
    always_comb begin
        nx_xmin = fe ? '1 : acc_xmin;
        nx_xmax = fe ? '0 : acc_xmax;
        nx_ymin = fe ? '1 : acc_ymin;
        nx_ymax = fe ? '0 : acc_ymax;
        nx_cnt  = fe ? '0 : acc_cnt;
        if (s1.mk) begin
            if (s1.x < nx_xmin) nx_xmin = s1.x;
            if (s1.x > nx_xmax) nx_xmax = s1.x;
            if (s1.y < nx_ymin) nx_ymin = s1.y;
            if (s1.y > nx_ymax) nx_ymax = s1.y;
            if (~&nx_cnt)       nx_cnt  = nx_cnt + 1'b1;
        end
    end

    state_t state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= UNSYNC;
            acc_xmin   <= '1;
            acc_xmax   <= '0;
            acc_ymin   <= '1;
            acc_ymax   <= '0;
            acc_cnt    <= '0;
            x_min      <= '1;
            x_max      <= '0;
            y_min      <= '1;
            y_max      <= '0;
            pix_count  <= '0;
            bbox_valid <= 1'b0;
            frame_done <= 1'b0;
        end else if (ce) begin
            acc_xmin   <= nx_xmin;
            acc_xmax   <= nx_xmax;
            acc_ymin   <= nx_ymin;
            acc_ymax   <= nx_ymax;
            acc_cnt    <= nx_cnt;
            frame_done <= 1'b0;
            if (fe) begin
                case (state)
                    // first edge after reset only aligns to the frame; the
                    // partial frame seen so far is discarded
                    UNSYNC: state <= RUN;
                    RUN: begin
                        x_min      <= acc_xmin;
                        x_max      <= acc_xmax;
                        y_min      <= acc_ymin;
                        y_max      <= acc_ymax;
                        pix_count  <= acc_cnt;
                        bbox_valid <= (acc_cnt != '0);
                        frame_done <= 1'b1;
                    end
                    default: state <= UNSYNC;
                endcase
            end
        end
    end

    logic on_col, on_row, border;

    always_comb begin
        on_col = ((s1.x == x_min) || (s1.x == x_max)) && (s1.y >= y_min) && (s1.y <= y_max);
        on_row = ((s1.y == y_min) || (s1.y == y_max)) && (s1.x >= x_min) && (s1.x <= x_max);
        border = bbox_valid & s1.de & (on_col | on_row);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            R         <= '0;
            G         <= '0;
            B         <= '0;
            out_de    <= 1'b0;
            out_hsync <= 1'b0;
            out_vsync <= 1'b0;
        end else if (ce) begin
            R         <= (s1.de & (border | s1.mk))  ? 8'hFF : 8'h00;
            G         <= (s1.de & ~border & s1.mk)   ? 8'hFF : 8'h00;
            B         <= (s1.de & ~border & s1.mk)   ? 8'hFF : 8'h00;
            out_de    <= s1.de;
            out_hsync <= s1.hs;
            out_vsync <= s1.vs;
        end
    end

endmodule

// File: tb/tb_hsv_mask_bbox.sv
// Bench for hsv_mask_bbox: two instances (plain and wrapped hue range) driven
// with 16x8 frames and compared every cycle against a frame-level model.
module tb_hsv_mask_bbox;

    localparam int W  = 16;
    localparam int HT = 8;

    typedef struct packed {
        logic [7:0]  r, g, b;
        logic        de, hs, vs;
        logic [10:0] xmin, xmax, ymin, ymax;
        logic [21:0] cnt;
        logic        valid, done;
    } obs_t;

    typedef struct packed { obs_t a; obs_t w; } pair_t;
    typedef struct { int k; int x; int y; } pt_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ce = 1'b1;
    logic [7:0] h = '0, s = '0, v = '0;
    logic       de = 1'b0, hs = 1'b0, vs = 1'b0;

    logic [7:0]  r_a, g_a, b_a, r_w, g_w, b_w;
    logic        de_a, hs_a, vs_a, de_w, hs_w, vs_w;
    logic [10:0] xmin_a, xmax_a, ymin_a, ymax_a, xmin_w, xmax_w, ymin_w, ymax_w;
    logic [21:0] cnt_a, cnt_w;
    logic        valid_a, done_a, valid_w, done_w;

    always #5 clk = ~clk;

    hsv_mask_bbox dut_a (
        .clk(clk), .rst_n(rst_n), .ce(ce), .H(h), .S(s), .V(v),
        .in_de(de), .in_hsync(hs), .in_vsync(vs),
        .R(r_a), .G(g_a), .B(b_a), .out_de(de_a), .out_hsync(hs_a), .out_vsync(vs_a),
        .x_min(xmin_a), .x_max(xmax_a), .y_min(ymin_a), .y_max(ymax_a),
        .pix_count(cnt_a), .bbox_valid(valid_a), .frame_done(done_a)
    );

    hsv_mask_bbox #(.H_MIN(8'd240), .H_MAX(8'd10)) dut_w (
        .clk(clk), .rst_n(rst_n), .ce(ce), .H(h), .S(s), .V(v),
        .in_de(de), .in_hsync(hs), .in_vsync(vs),
        .R(r_w), .G(g_w), .B(b_w), .out_de(de_w), .out_hsync(hs_w), .out_vsync(vs_w),
        .x_min(xmin_w), .x_max(xmax_w), .y_min(ymin_w), .y_max(ymax_w),
        .pix_count(cnt_w), .bbox_valid(valid_w), .frame_done(done_w)
    );

    obs_t obs_a, obs_w;
    assign obs_a = {r_a, g_a, b_a, de_a, hs_a, vs_a, xmin_a, xmax_a, ymin_a, ymax_a, cnt_a, valid_a, done_a};
    assign obs_w = {r_w, g_w, b_w, de_w, hs_w, vs_w, xmin_w, xmax_w, ymin_w, ymax_w, cnt_w, valid_w, done_w};

    // model state
    obs_t       rst_obs;
    obs_t       rep [2];
    pt_t        pts [$];
    pair_t      q [$];
    pair_t      last;
    bit         synced, prev_vs, prev_ce;
    int         n_vec, n_err;
    logic [7:0] ph [HT][W];
    logic [7:0] ps [HT][W];
    logic [7:0] pv [HT][W];

    function automatic bit in_mask(input int k, input logic [7:0] hh, ss, vv);
        int hmin, hmax;
        bit hin;
        hmin = (k == 1) ? 240 : 0;
        hmax = (k == 1) ? 10 : 20;
        if (hmin <= hmax) hin = (int'(hh) >= hmin) && (int'(hh) <= hmax);
        else              hin = (int'(hh) >= hmin) || (int'(hh) <= hmax);
        return hin && int'(ss) >= 80 && int'(ss) <= 255 && int'(vv) >= 60 && int'(vv) <= 255;
    endfunction

    task automatic close_frame();
        int xmn, xmx, ymn, ymx, cnt;
        for (int k = 0; k < 2; k++) begin
            xmn = 2047; xmx = 0; ymn = 2047; ymx = 0; cnt = 0;
            foreach (pts[i]) begin
                if (pts[i].k == k) begin
                    if (pts[i].x < xmn) xmn = pts[i].x;
                    if (pts[i].x > xmx) xmx = pts[i].x;
                    if (pts[i].y < ymn) ymn = pts[i].y;
                    if (pts[i].y > ymx) ymx = pts[i].y;
                    cnt++;
                end
            end
            rep[k].xmin  = 11'(xmn);
            rep[k].xmax  = 11'(xmx);
            rep[k].ymin  = 11'(ymn);
            rep[k].ymax  = 11'(ymx);
            rep[k].cnt   = 22'(cnt);
            rep[k].valid = (cnt != 0);
        end
    endtask

    task automatic model_step(input bit d, hsy, vsy, input logic [7:0] hh, ss, vv,
                              input int x, y, output pair_t e);
        bit   rise, done, m, brd;
        obs_t o [2];
        rise    = vsy && !prev_vs;
        prev_vs = vsy;
        done    = 1'b0;
        if (rise) begin
            if (synced) begin
                close_frame();
                done = 1'b1;
            end
            synced = 1'b1;
            pts.delete();
        end
        for (int k = 0; k < 2; k++) begin
            m = d && in_mask(k, hh, ss, vv);
            if (m) pts.push_back('{k, x, y});
            o[k]      = rep[k];
            o[k].de   = d;
            o[k].hs   = hsy;
            o[k].vs   = vsy;
            o[k].done = done;
            brd = rep[k].valid && d &&
                  (((x == int'(rep[k].xmin) || x == int'(rep[k].xmax)) &&
                    y >= int'(rep[k].ymin) && y <= int'(rep[k].ymax)) ||
                   ((y == int'(rep[k].ymin) || y == int'(rep[k].ymax)) &&
                    x >= int'(rep[k].xmin) && x <= int'(rep[k].xmax)));
            {o[k].r, o[k].g, o[k].b} = !d ? 24'h000000 : brd ? 24'hFF0000 : m ? 24'hFFFFFF : 24'h000000;
        end
        e.a = o[0];
        e.w = o[1];
    endtask

    task automatic check(input string tag, input pair_t e);
        n_vec += 2;
        assert (obs_a === e.a) else begin
            n_err++;
            $error("FAIL %s dut_a t=%0t got %h want %h", tag, $time, obs_a, e.a);
        end
        assert (obs_w === e.w) else begin
            n_err++;
            $error("FAIL %s dut_w t=%0t got %h want %h", tag, $time, obs_w, e.w);
        end
    endtask

    // One input cycle: check what is due at the outputs, then drive.
    task automatic tick(input bit c, input bit d, hsy, vsy, input logic [7:0] hh, ss, vv,
                        input int x, y);
        pair_t e;
        @(negedge clk);
        if (!prev_ce) check("ce_hold", last);
        else if (q.size() == 2) begin
            last = q.pop_front();
            check("video", last);
        end
        ce = c; de = d; hs = hsy; vs = vsy; h = hh; s = ss; v = vv;
        if (c) begin
            model_step(d, hsy, vsy, hh, ss, vv, x, y, e);
            q.push_back(e);
        end
        prev_ce = c;
    endtask

    task automatic do_reset();
        pair_t e;
        @(negedge clk);
        rst_n = 1'b0;
        ce = 1'b1; de = 1'b0; hs = 1'b0; vs = 1'b0; h = '0; s = '0; v = '0;
        rep[0] = rst_obs; rep[1] = rst_obs;
        pts.delete(); q.delete();
        synced = 1'b0; prev_vs = 1'b0; prev_ce = 1'b1;
        #1;
        check("reset", '{a: rst_obs, w: rst_obs});
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            model_step(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, -1, -1, e);
            q.push_back(e);
        end
    endtask

    task automatic vsync_blank();
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 1'b0, i < 2, 8'd0, 8'd0, 8'd0, -1, -1);
    endtask

    task automatic run_frame(input int ce_row, input int ce_col, input int rst_row);
        vsync_blank();
        for (int yy = 0; yy < HT; yy++) begin
            for (int xx = 0; xx < W; xx++) begin
                if (yy == rst_row && xx == 6) begin
                    do_reset();
                    return;
                end
                if (yy == ce_row && xx == ce_col)
                    for (int i = 0; i < 5; i++)
                        tick(1'b0, 1'($urandom), 1'($urandom), 1'($urandom),
                             8'($urandom), 8'($urandom), 8'($urandom), -1, -1);
                tick(1'b1, 1'b1, 1'b0, 1'b0, ph[yy][xx], ps[yy][xx], pv[yy][xx], xx, yy);
            end
            for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, (i == 1 || i == 2), 1'b0, 8'd0, 8'd0, 8'd0, -1, -1);
        end
    endtask

    // 0 empty, 1 rectangle, 2 hue/threshold probes, 3 random, 4 single pixel
    task automatic fill(input int mode);
        for (int yy = 0; yy < HT; yy++)
            for (int xx = 0; xx < W; xx++) begin
                ph[yy][xx] = 8'd100; ps[yy][xx] = 8'd200; pv[yy][xx] = 8'd200;
                case (mode)
                    0: begin ps[yy][xx] = 8'd0; pv[yy][xx] = 8'd0; end
                    1: if (xx >= 3 && xx <= 6 && yy >= 2 && yy <= 4) ph[yy][xx] = 8'd10;
                    3: begin
                        ph[yy][xx] = 8'($urandom_range(0, 255));
                        ps[yy][xx] = 8'($urandom_range(60, 255));
                        pv[yy][xx] = 8'($urandom_range(40, 255));
                    end
                    4: if (xx == 0 && yy == 0) ph[yy][xx] = 8'd10;
                    default: ;
                endcase
            end
        if (mode == 2) begin
            ph[1][1] = 8'd250;
            ph[1][3] = 8'd5;
            ph[1][5] = 8'd11;
            ph[1][7] = 8'd239;
            ph[5][9]  = 8'd5; ps[5][9]  = 8'd80;  pv[5][9]  = 8'd255;
            ph[5][11] = 8'd5; ps[5][11] = 8'd79;
            ph[5][13] = 8'd5; ps[5][13] = 8'd255; pv[5][13] = 8'd60;
            ph[5][14] = 8'd5; pv[5][14] = 8'd59;
        end
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        rst_obs = '0; rst_obs.xmin = '1; rst_obs.ymin = '1;
        do_reset();

        fill(0); run_frame(-1, -1, -1); run_frame(-1, -1, -1);
        fill(1); run_frame(-1, -1, -1); run_frame(-1, -1, -1);
        fill(2); run_frame(-1, -1, -1);
        fill(3); run_frame(3, 7, -1);
        fill(3); run_frame(-1, -1, -1);
        fill(4); run_frame(-1, -1, -1); run_frame(-1, -1, -1);
        // reset mid-frame, then a resync-only frame before reporting resumes
        fill(1); run_frame(-1, -1, 4);
        run_frame(-1, -1, -1);
        fill(4); run_frame(-1, -1, -1);
        vsync_blank();
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, -1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hsv_mask_bbox.md
# hsv_mask_bbox

Downstream consumer of the rgb2hsv converter. Each pixel's H, S and V values are compared against inclusive thresholds to give a binary mask. Over each frame, the block accumulates the bounding box and pixel count of the mask. It outputs the mask as video, with the previous frame's bounding box drawn over it in red, and feeds the result to the HDMI output stage.

## Interface
- H_MIN, 8'd0: hue lower bound, inclusive
- H_MAX, 8'd20: hue upper bound, inclusive; H_MIN > H_MAX selects the wrap-around range
- S_MIN, 8'd80: saturation lower bound, inclusive
- S_MAX, 8'd255: saturation upper bound, inclusive
- V_MIN, 8'd60: value lower bound, inclusive
- V_MAX, 8'd255: value upper bound, inclusive
- CW, 11: width of the coordinate counters

Ports:
- clk  in  1  pixel clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ce  in  1  clock enable; when low, all registers hold
- H, S, V  in  8 each  pixel from rgb2hsv
- in_de, in_hsync, in_vsync  in  1 each  active-high syncs aligned with H/S/V
- R, G, B  out  8 each  overlay video
- out_de, out_hsync, out_vsync  out  1 each  syncs delayed 2 cycles
- x_min, x_max, y_min, y_max  out  CW each  bounding box latched at the end of the last complete frame
- pix_count  out  22  number of mask pixels in the last complete frame; saturates at 22'h3FFFFF
- bbox_valid  out  1  the last complete frame contained at least 1 mask pixel
- frame_done  out  1  single-cycle pulse when the results are latched

## Operation
- **Mask** (combinational, registered into stage 1):
  - m = hin & (S_MIN ≤ S ≤ S_MAX) & (V_MIN ≤ V ≤ V_MAX)
  - hin = (H_MIN ≤ H ≤ H_MAX) when H_MIN ≤ H_MAX
  - hin = (H ≥ H_MIN) | (H ≤ H_MAX) otherwise
  - Effective mask mk = m & in_de.
- **Stage 1** registers mk, x, y, de1, hs1, vs1 and vs2 (vs1 delayed once more).
- **x counter:** increments on every cycle with in_de = 1. Cleared on the cycle after in_de falls. Value 0 is the first pixel of a line.
- **y counter:**
  - increments when in_de falls
  - cleared on a rising edge of in_vsync
  - takes priority over the increment if both occur
- Counters wrap modulo 2^CW. This is not flagged.
- **Frame edge** fe = vs1 & ~vs2.
- **Accumulators** (acc_xmin, acc_xmax, acc_ymin, acc_ymax, acc_cnt), updated from stage-1 signals:
  - On each mk1 cycle: mins take min(acc, coord), maxes take max(acc, coord), acc_cnt increments (saturating).
  - Empty state: mins = all-ones, maxes = 0, cnt = 0.
- **On fe:**
  - Copy the accumulators to the outputs.
  - Set bbox_valid = (acc_cnt ≠ 0) and pulse frame_done.
  - Return the accumulators to the empty state. If mk1 is also asserted on the fe cycle, that pixel is loaded as the first pixel of the new frame.
- **Sync FSM** (states UNSYNC and RUN):
  - Reset enters UNSYNC.
  - The first fe moves to RUN. It only clears the accumulators: no latch, no frame_done, so a partial frame is never reported.
  - In RUN, every fe latches as above.
- **Stage 2** (overlay):
  - border = bbox_valid & de1 & ((x1 == x_min or x1 == x_max) & y_min ≤ y1 ≤ y_max, or (y1 == y_min or y1 == y_max) & x_min ≤ x1 ≤ x_max).
  - {R,G,B} = border ? FF,00,00 : mk1 ? FF,FF,FF : 00,00,00.
  - Forced to 0 when de1 = 0.
- The overlay always uses the latched box from the previous frame, never the box being accumulated.

## Timing
- Video latency is 2 cycles from H/S/V and syncs to R/G/B and out_* syncs, with ce = 1 throughout.
- A vsync rising edge at input cycle t gives fe at cycle t+1. The new results and the frame_done pulse are visible at t+2.
- ce = 0 freezes every register, including frame_done. A pulse that is high stays high until ce returns.
- Reset values: R/G/B = 0, out_* = 0, x_min/y_min = all-ones, x_max/y_max = 0, pix_count = 0, bbox_valid = 0, frame_done = 0, FSM = UNSYNC.
- Reset asserted mid-frame clears everything immediately. The frame in progress is lost, and the next vsync edge only resynchronizes.

## Test plan
- **Reset, then 2 frames of 16x8 with no mask pixels.** Expect the first vsync edge to give no frame_done. The second gives frame_done with bbox_valid = 0 and pix_count = 0. Output video is all black.
- **Rectangle:** H=10, S=200, V=200 at x=3..6, y=2..4, other pixels H=100. Expect x_min=3, x_max=6, y_min=2, y_max=4, pix_count=12. In the next frame, red is drawn exactly on the rectangle perimeter and the 2 interior pixels are white.
- **Hue wrap** with H_MIN=240, H_MAX=10. Expect pixels with H=250 and H=5 in the mask, and H=11 and H=239 not in the mask.
- **Boundary thresholds:** S=S_MIN, V=V_MAX in the mask; S=S_MIN-1 not in the mask.
- **Single pixel at (0,0).** Expect x_min=x_max=0, y_min=y_max=0, pix_count=1.
- **Latency and ce:**
  - R/G/B and syncs trail the input by exactly 2 cycles.
  - A ce = 0 burst of 5 cycles mid-line holds all outputs.
  - rst_n pulsed mid-frame: outputs go to reset values immediately and the next frame is unreported.
